// File: rtl/game_pkg.sv
// Shared game-flow definitions: state codes and widths used by the controller,
// the renderer and the score blocks.
package game_pkg;

    localparam int STATE_W = 3;
    localparam int LIVES_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_START        = 3'd0,
        ST_INSTRUCTIONS = 3'd1,
        ST_COUNTDOWN    = 3'd2,
        ST_PLAYING      = 3'd3,
        ST_PAUSED       = 3'd4,
        ST_RESPAWN      = 3'd5,
        ST_GAME_OVER    = 3'd6
    } game_state_t;

endpackage

// File: rtl/key_debouncer.sv
// Debounces one active-low raw key and emits a one-cycle pulse when the
// debounced level falls (the key is accepted as pressed).
module key_debouncer #(
    parameter int DB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic          level;
    logic [CW-1:0] cnt;

    // The counter only runs while raw disagrees with the accepted level; any
    // agreeing cycle restarts the qualification window.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (raw != level) begin
                if (cnt == LAST) begin
                    level <= raw;
                    cnt   <= '0;
                    press <= level & ~raw;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/game_flow_controller.sv
// Top-level game flow: debounced keys drive the title/countdown/play/pause/
// respawn/game-over sequence, tracking lives and a shared phase timer.
module game_flow_controller
    import game_pkg::*;
#(
    parameter int DB_CYCLES     = 50000,
    parameter int LIVES         = 3,
    parameter int COUNTDOWN_CYC = 150000000,
    parameter int INVULN_CYC    = 100000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_action,
    input  logic               key_instr,
    input  logic               key_pause,
    input  logic               collision,
    output logic [STATE_W-1:0] state,
    output logic [LIVES_W-1:0] lives,
    output logic               invulnerable,
    output logic               start_pulse
);

    localparam int PHASE_MAX = (COUNTDOWN_CYC > INVULN_CYC) ? COUNTDOWN_CYC : INVULN_CYC;
    localparam int TW        = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
    localparam logic [TW-1:0]      CD_LOAD    = TW'(COUNTDOWN_CYC - 1);
    localparam logic [TW-1:0]      IV_LOAD    = TW'(INVULN_CYC - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

    logic action_ev, instr_ev, pause_ev;

    key_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_action (
        .clk(clk), .rst(rst), .raw(key_action), .press(action_ev)
    );
    key_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_instr (
        .clk(clk), .rst(rst), .raw(key_instr), .press(instr_ev)
    );
    key_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
        .clk(clk), .rst(rst), .raw(key_pause), .press(pause_ev)
    );

    game_state_t        state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [LIVES_W-1:0] lives_d;
    logic               start_pulse_d, invuln_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_START;
            timer_q      <= '0;
            lives        <= LIVES_INIT;
            start_pulse  <= 1'b0;
            invulnerable <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            lives        <= lives_d;
            start_pulse  <= start_pulse_d;
            invulnerable <= invuln_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        lives_d       = lives;
        start_pulse_d = 1'b0;

        case (state_q)
            ST_START: begin
                if (action_ev) begin
                    state_d       = ST_COUNTDOWN;
                    lives_d       = LIVES_INIT;
                    start_pulse_d = 1'b1;
                end else if (instr_ev) begin
                    state_d = ST_INSTRUCTIONS;
                end
            end
            ST_INSTRUCTIONS: begin
                if (action_ev || instr_ev) state_d = ST_START;
            end
            ST_COUNTDOWN, ST_RESPAWN: begin
                if (timer_q == '0) state_d = ST_PLAYING;
                else               timer_d = timer_q - TW'(1);
            end
            ST_PLAYING: begin
                if (collision) begin
                    if (lives > LIVES_W'(1)) begin
                        state_d = ST_RESPAWN;
                        lives_d = lives - LIVES_W'(1);
                    end else begin
                        state_d = ST_GAME_OVER;
                        lives_d = '0;
                    end
                end else if (pause_ev) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (pause_ev)       state_d = ST_PLAYING;
                else if (action_ev) state_d = ST_START;
            end
            ST_GAME_OVER: begin
                lives_d = '0;
                if (action_ev) state_d = ST_START;
            end
            default: state_d = ST_START;
        endcase

        // Every state entry reloads the phase timer, so timed states always
        // last exactly their configured number of cycles.
        if (state_d != state_q) begin
            case (state_d)
                ST_COUNTDOWN: timer_d = CD_LOAD;
                ST_RESPAWN:   timer_d = IV_LOAD;
                default:      timer_d = '0;
            endcase
        end

        invuln_d = (state_d == ST_RESPAWN);
    end

    assign state = state_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Self-checking bench for game_flow_controller with short debounce and phase
// timers; vectors carry hand-derived expected outputs per cycle.
module tb_game_flow_controller;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] lv;
        logic       inv;
        logic       sp;
    } exp_t;

    typedef struct {
        logic rst;
        logic act;
        logic ins;
        logic pau;
        logic col;
        int   reps;
        exp_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_action = 1'b1;
    logic       key_instr = 1'b1;
    logic       key_pause = 1'b1;
    logic       collision = 1'b0;
    logic [2:0] state;
    logic [3:0] lives;
    logic       invulnerable;
    logic       start_pulse;

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    game_flow_controller #(
        .DB_CYCLES(4),
        .LIVES(3),
        .COUNTDOWN_CYC(8),
        .INVULN_CYC(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_action(key_action),
        .key_instr(key_instr),
        .key_pause(key_pause),
        .collision(collision),
        .state(state),
        .lives(lives),
        .invulnerable(invulnerable),
        .start_pulse(start_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(logic r, logic a, logic i, logic p, logic c,
                                int n, int st, int lv, logic inv, logic sp);
        vec_t v;
        v.rst     = r;
        v.act     = a;
        v.ins     = i;
        v.pau     = p;
        v.col     = c;
        v.reps    = n;
        v.exp.st  = 3'(st);
        v.exp.lv  = 4'(lv);
        v.exp.inv = inv;
        v.exp.sp  = sp;
        return v;
    endfunction

    // a/i/p are "key held pressed" flags; the pins themselves are active-low
    task automatic applyStimulus(input logic r, input logic a, input logic i,
                                 input logic p, input logic c, input exp_t e);
        rst        = r;
        key_action = ~a;
        key_instr  = ~i;
        key_pause  = ~p;
        collision  = c;
        sb_q.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        exp_t got;
        got = {state, lives, invulnerable, start_pulse};
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL %s: scoreboard empty, got st=%0d lv=%0d inv=%0b sp=%0b",
                     tag, state, lives, invulnerable, start_pulse);
        end else begin
            e = sb_q.pop_front();
            if (got !== e) begin
                n_fail++;
                $display("[TB] FAIL %s: got st=%0d lv=%0d inv=%0b sp=%0b, want st=%0d lv=%0d inv=%0b sp=%0b",
                         tag, state, lives, invulnerable, start_pulse, e.st, e.lv, e.inv, e.sp);
            end
        end
    endtask

    task automatic stepCheck(input logic r, input logic a, input logic i,
                             input logic p, input logic c, input exp_t e, input string tag);
        applyStimulus(r, a, i, p, c, e);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic checkValue(input string tag, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    // Idles the keys and counts cycles until PLAYING, also counting cycles where
    // invulnerable disagrees with the RESPAWN state code.
    task automatic waitForPlaying(input int budget, output int n, output int inv_bad);
        exp_t dummy;
        n       = 0;
        inv_bad = 0;
        dummy   = '0;
        for (int k = 0; k < budget; k++) begin
            rst = 1'b0; key_action = 1'b1; key_instr = 1'b1; key_pause = 1'b1; collision = 1'b0;
            @(posedge clk);
            #1;
            n++;
            if (invulnerable !== (state == 3'd5)) inv_bad++;
            if (state == 3'd3) break;
        end
        if (state != 3'd3) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL wait_playing: state=%0d after %0d cycles, want 3", state, budget);
        end
        if (dummy != 0) sb_q.push_back(dummy);
    endtask

    initial begin
        int n;
        int bad;

        // reset
        vecs.push_back(mk(1,0,0,0,0, 2, 0,3,0,0));
        // instructions entry and exit
        vecs.push_back(mk(0,0,1,0,0, 4, 0,3,0,0));
        vecs.push_back(mk(0,0,1,0,0, 1, 1,3,0,0));
        vecs.push_back(mk(0,0,0,0,0, 4, 1,3,0,0));
        vecs.push_back(mk(0,1,0,0,0, 4, 1,3,0,0));
        vecs.push_back(mk(0,1,0,0,0, 1, 0,3,0,0));
        vecs.push_back(mk(0,0,0,0,0, 4, 0,3,0,0));
        // short bounce rejected, long press starts countdown
        vecs.push_back(mk(0,1,0,0,0, 3, 0,3,0,0));
        vecs.push_back(mk(0,0,0,0,0, 1, 0,3,0,0));
        vecs.push_back(mk(0,1,0,0,0, 4, 0,3,0,0));
        vecs.push_back(mk(0,1,0,0,0, 1, 2,3,0,1));
        vecs.push_back(mk(0,1,0,0,0, 1, 2,3,0,0));
        // pause press and collision ignored during countdown
        vecs.push_back(mk(0,0,0,1,1, 5, 2,3,0,0));
        vecs.push_back(mk(0,0,0,0,0, 1, 2,3,0,0));
        vecs.push_back(mk(0,0,0,0,0, 1, 3,3,0,0));
        // three hits; collisions during respawn and game over ignored
        vecs.push_back(mk(0,0,0,0,1, 1, 5,2,1,0));
        vecs.push_back(mk(0,0,0,0,1, 4, 5,2,1,0));
        vecs.push_back(mk(0,0,0,0,0, 1, 3,2,0,0));
        vecs.push_back(mk(0,0,0,0,0, 2, 3,2,0,0));
        vecs.push_back(mk(0,0,0,0,1, 1, 5,1,1,0));
        vecs.push_back(mk(0,0,0,0,0, 4, 5,1,1,0));
        vecs.push_back(mk(0,0,0,0,0, 1, 3,1,0,0));
        vecs.push_back(mk(0,0,0,0,1, 1, 6,0,0,0));
        vecs.push_back(mk(0,0,0,0,1, 2, 6,0,0,0));
        vecs.push_back(mk(0,1,0,0,0, 4, 6,0,0,0));
        vecs.push_back(mk(0,1,0,0,0, 1, 0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 4, 0,0,0,0));
        // new game, pause/resume, collision while paused, pause then quit
        vecs.push_back(mk(0,1,0,0,0, 4, 0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0, 1, 2,3,0,1));
        vecs.push_back(mk(0,0,0,0,0, 4, 2,3,0,0));
        vecs.push_back(mk(0,0,0,0,0, 3, 2,3,0,0));
        vecs.push_back(mk(0,0,0,0,0, 1, 3,3,0,0));
        vecs.push_back(mk(0,0,0,1,0, 4, 3,3,0,0));
        vecs.push_back(mk(0,0,0,1,0, 1, 4,3,0,0));
        vecs.push_back(mk(0,0,0,0,1, 4, 4,3,0,0));
        vecs.push_back(mk(0,0,0,1,0, 4, 4,3,0,0));
        vecs.push_back(mk(0,0,0,1,0, 1, 3,3,0,0));
        vecs.push_back(mk(0,0,0,0,0, 4, 3,3,0,0));
        vecs.push_back(mk(0,0,0,1,0, 4, 3,3,0,0));
        vecs.push_back(mk(0,0,0,1,0, 1, 4,3,0,0));
        vecs.push_back(mk(0,0,0,0,0, 4, 4,3,0,0));
        vecs.push_back(mk(0,1,0,0,0, 4, 4,3,0,0));
        vecs.push_back(mk(0,1,0,0,0, 1, 0,3,0,0));
        vecs.push_back(mk(0,0,0,0,0, 4, 0,3,0,0));
        // action beats instr in START; collision beats pause in PLAYING
        vecs.push_back(mk(0,1,1,0,0, 4, 0,3,0,0));
        vecs.push_back(mk(0,1,1,0,0, 1, 2,3,0,1));
        vecs.push_back(mk(0,0,0,0,0, 4, 2,3,0,0));
        vecs.push_back(mk(0,0,0,0,0, 3, 2,3,0,0));
        vecs.push_back(mk(0,0,0,0,0, 1, 3,3,0,0));
        vecs.push_back(mk(0,0,0,1,0, 4, 3,3,0,0));
        vecs.push_back(mk(0,0,0,1,1, 1, 5,2,1,0));
        vecs.push_back(mk(0,0,0,0,0, 4, 5,2,1,0));
        vecs.push_back(mk(0,0,0,0,0, 1, 3,2,0,0));
        // reset in the middle of the last-life respawn
        vecs.push_back(mk(0,0,0,0,1, 1, 5,1,1,0));
        vecs.push_back(mk(0,0,0,0,0, 2, 5,1,1,0));
        vecs.push_back(mk(1,0,0,0,0, 1, 0,3,0,0));
        vecs.push_back(mk(0,0,0,0,0, 1, 0,3,0,0));

        for (int v = 0; v < vecs.size(); v++) begin
            for (int r = 0; r < vecs[v].reps; r++) begin
                stepCheck(vecs[v].rst, vecs[v].act, vecs[v].ins, vecs[v].pau, vecs[v].col,
                          vecs[v].exp, $sformatf("vec%0d.%0d", v, r));
            end
        end

        // key held through reset: press qualifies DB_CYCLES cycles after release
        stepCheck(1,1,0,0,0, {3'd0,4'd3,1'b0,1'b0}, "held_rst.0");
        stepCheck(1,1,0,0,0, {3'd0,4'd3,1'b0,1'b0}, "held_rst.1");
        for (int k = 0; k < 4; k++)
            stepCheck(0,1,0,0,0, {3'd0,4'd3,1'b0,1'b0}, $sformatf("held_rel.%0d", k));
        stepCheck(0,1,0,0,0, {3'd2,4'd3,1'b0,1'b1}, "held_event");

        // reset in the middle of the countdown
        stepCheck(0,0,0,0,0, {3'd2,4'd3,1'b0,1'b0}, "cd_mid.0");
        stepCheck(0,0,0,0,0, {3'd2,4'd3,1'b0,1'b0}, "cd_mid.1");
        stepCheck(1,0,0,0,0, {3'd0,4'd3,1'b0,1'b0}, "cd_rst");
        stepCheck(0,0,0,0,0, {3'd0,4'd3,1'b0,1'b0}, "cd_after_rst.0");
        stepCheck(0,0,0,0,0, {3'd0,4'd3,1'b0,1'b0}, "cd_after_rst.1");

        // countdown and respawn durations measured against a cycle budget
        for (int k = 0; k < 4; k++)
            stepCheck(0,1,0,0,0, {3'd0,4'd3,1'b0,1'b0}, $sformatf("cd_press.%0d", k));
        stepCheck(0,1,0,0,0, {3'd2,4'd3,1'b0,1'b1}, "cd_enter");
        waitForPlaying(40, n, bad);
        checkValue("countdown_len", n, 8);
        checkValue("countdown_inv", bad, 0);
        stepCheck(0,0,0,0,1, {3'd5,4'd2,1'b1,1'b0}, "iv_enter");
        waitForPlaying(40, n, bad);
        checkValue("respawn_len", n, 5);
        checkValue("respawn_inv", bad, 0);
        checkValue("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
